// File: rtl/usart_rx_fifo.sv
// usart_rx_fifo: 8N1 serial receiver feeding a byte FIFO with a valid/ready read port and sticky error flags
module usart_rx_fifo #(
  parameter int CLOCKS_PER_BIT = 868,
  parameter int CLOCKS_WAIT_FOR_RECEIVE = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     frame_err,
  output logic                     overflow,
  input  logic                     err_clear
);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] START_END = CW'(CLOCKS_WAIT_FOR_RECEIVE - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic [7:0] mem [2**FIFO_DEPTH_LOG2];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic stop_done, pop, push;
  always_comb begin
    rd_valid = fifo_count != '0;
    rd_data = rd_valid ? mem[rd_ptr] : '0;
    stop_done = state == STOP && cnt == BIT_END;
    pop = rd_valid && rd_ready;
    // the count MSB is set only when the FIFO is completely full
    push = stop_done && rx_s && (!fifo_count[FIFO_DEPTH_LOG2] || pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      cnt <= (state == IDLE || cnt == BIT_END || (state == START && cnt == START_END)) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (!rx_s) state <= START;
        START: if (cnt == START_END) begin
          state <= rx_s ? IDLE : DATA;
          idx <= '0;
        end
        DATA: if (cnt == BIT_END) begin
          shift[idx] <= rx_s;
          idx <= idx + 1'b1;
          if (idx == 3'd7) state <= STOP;
        end
        STOP: if (cnt == BIT_END) state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= (push && !pop) ? fifo_count + 1'b1 : (pop && !push) ? fifo_count - 1'b1 : fifo_count;
      frame_err <= !err_clear && (frame_err || (stop_done && !rx_s));
      overflow <= !err_clear && (overflow || (stop_done && rx_s && !push));
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end
endmodule

// File: tb/tb_usart_rx_fifo.sv
// tb_usart_rx_fifo: directed table-driven bench for the 8N1 receiver FIFO
module tb_usart_rx_fifo;
  logic clk = 1'b0;
  logic reset, rx, rd_valid, rd_ready, frame_err, overflow, err_clear;
  logic [7:0] rd_data;
  logic [4:0] fifo_count;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       drain;
    int         exp_count;
    int         exp_head;
    int         exp_ferr;
    int         exp_ovf;
  } vec_t;
  vec_t vecs [3];

  always #5 clk = ~clk;

  usart_rx_fifo #(.CLOCKS_PER_BIT(8), .CLOCKS_WAIT_FOR_RECEIVE(4), .FIFO_DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .fifo_count(fifo_count), .frame_err(frame_err),
    .overflow(overflow), .err_clear(err_clear)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // one 8-bit-time-per-bit frame; pop raises rd_ready for the push cycle only
  task automatic send(input logic [7:0] d, input logic stop, input logic pop, input logic tchk);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        if (tchk && b == 9 && j == 6) chk("valid_before_push", int'(rd_valid), 0);
        if (tchk && b == 9 && j == 7) chk("valid_after_push", int'(rd_valid), 1);
        rx = bits[b];
        if (b == 9) rd_ready = pop && j == 6;
      end
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 0, 1, 0};
    vecs[2] = '{8'h55, 1'b1, 1'b1, 1, 8'h55, 1, 0};
    reset = 1'b1;
    rx = 1'b1;
    rd_ready = 1'b0;
    err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_data", int'(rd_data), 0);
    reset = 1'b0;
    idle(5);

    for (int i = 0; i < 3; i++) begin
      send(vecs[i].data, vecs[i].stop, 1'b0, i == 0);
      idle(20);
      chk($sformatf("v%0d_count", i), int'(fifo_count), vecs[i].exp_count);
      chk($sformatf("v%0d_valid", i), int'(rd_valid), int'(vecs[i].exp_count != 0));
      chk($sformatf("v%0d_ferr", i), int'(frame_err), vecs[i].exp_ferr);
      chk($sformatf("v%0d_ovf", i), int'(overflow), vecs[i].exp_ovf);
      if (vecs[i].exp_count != 0) chk($sformatf("v%0d_head", i), int'(rd_data), vecs[i].exp_head);
      if (vecs[i].drain) begin
        pop_one();
        chk($sformatf("v%0d_drain_count", i), int'(fifo_count), 0);
        chk($sformatf("v%0d_drain_valid", i), int'(rd_valid), 0);
      end
    end
    clear_errs();
    chk("ferr_cleared", int'(frame_err), 0);

    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    chk("glitch_count", int'(fifo_count), 0);
    chk("glitch_ferr", int'(frame_err), 0);
    chk("glitch_ovf", int'(overflow), 0);
    rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    rd_ready = 1'b0;
    chk("underflow_count", int'(fifo_count), 0);

    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("ovf_count", int'(fifo_count), 16);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_ferr", int'(frame_err), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_drain%0d", i), int'(rd_data), i);
      pop_one();
    end
    chk("ovf_drained", int'(fifo_count), 0);
    clear_errs();
    chk("ovf_cleared", int'(overflow), 0);

    for (int i = 0; i < 16; i++) send(8'(32 + i), 1'b1, 1'b0, 1'b0);
    send(8'h30, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("fullpop_count", int'(fifo_count), 16);
    chk("fullpop_ovf", int'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullpop_drain%0d", i), int'(rd_data), 33 + i);
      pop_one();
    end
    chk("fullpop_drained", int'(fifo_count), 0);

    send(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(20);
    send(8'h77, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("pre_rst_ferr", int'(frame_err), 1);
    chk("pre_rst_count", int'(fifo_count), 1);
    for (int j = 0; j < 28; j++) begin
      @(negedge clk);
      rx = j < 8 ? 1'b0 : 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", int'(rd_valid), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_ferr", int'(frame_err), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_data", int'(rd_data), 0);
    reset = 1'b0;
    idle(20);
    chk("post_rst_count", int'(fifo_count), 0);
    send(8'h81, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("post_rst_rx_count", int'(fifo_count), 1);
    chk("post_rst_rx_data", int'(rd_data), 8'h81);
    chk("post_rst_rx_ferr", int'(frame_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
